// File: rtl/serial_alu_pkg.sv
// Shared encodings for the digit-serial adder/subtractor: FSM states and operation select.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-add stages; chained DIGIT times per slice.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic h1_s, h1_c, h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;
  assign s    = h1_s ^ cin;
  assign h2_c = h1_s & cin;
  assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract, DIGIT bits per clock, LSB slice first, start/done handshake.
// Define SERIAL_ADD_SUB_OVF_EN to generate the signed-overflow flag; otherwise ovf is tied low.
module serial_add_sub
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             zero,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_e           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, sum_q, sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, zero_q;

  logic [IW-1:0]    base;
  logic [DIGIT-1:0] a_slice, b_slice, s_slice;
  logic [DIGIT:0]   chain;
  logic             accept, last_step;

  assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_step = (state_q == ST_RUN) && (cnt_q == LAST);

  // Bit offset of the slice being processed; never exceeds WIDTH-DIGIT.
  assign base    = IW'(cnt_q) * IW'(DIGIT);
  assign a_slice = opa_q[base +: DIGIT];
  assign b_slice = opb_q[base +: DIGIT];
  assign chain[0] = carry_q;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    fa_cell u_fa (
      .a    (a_slice[gi]),
      .b    (b_slice[gi]),
      .cin  (chain[gi]),
      .s    (s_slice[gi]),
      .cout (chain[gi+1])
    );
  end

  always_comb begin
    sum_d = sum_q;
    sum_d[base +: DIGIT] = s_slice;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            // Subtraction is a + ~b + 1: invert B here, inject the +1 as the initial carry.
            opa_q   <= a;
            opb_q   <= (sub == OP_ADD) ? b : ~b;
            carry_q <= (sub == OP_SUB);
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= chain[DIGIT];
          if (last_step) begin
            cnt_q   <= '0;
            cout_q  <= chain[DIGIT];
            zero_q  <= (sum_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      ovf_q <= 1'b0;
    end else if (last_step) begin
      ovf_q <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum_d[WIDTH-1] != opa_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: an 8-bit/1-digit and a 16-bit/4-digit instance, table vectors,
// handshake/reset sequences and random operations against an integer-arithmetic model.
module tb_serial_add_sub;

`ifdef SERIAL_ADD_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  start_v = 2'b00;
  logic        sub_v = 1'b0;
  logic [15:0] a_v = '0, b_v = '0;

  logic [1:0]  busy_o, done_o, cout_o, zero_o, ovf_o;
  logic [7:0]  sum0;
  logic [15:0] sum1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub_v),
    .a(a_v[7:0]), .b(b_v[7:0]), .busy(busy_o[0]), .done(done_o[0]),
    .sum(sum0), .carry_out(cout_o[0]), .zero(zero_o[0]), .ovf(ovf_o[0])
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub_v),
    .a(a_v), .b(b_v), .busy(busy_o[1]), .done(done_o[1]),
    .sum(sum1), .carry_out(cout_o[1]), .zero(zero_o[1]), .ovf(ovf_o[1])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       zero;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] get_sum(input int sel);
    return (sel == 1) ? sum1 : {8'h00, sum0};
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input longint ua, input longint ub, input bit s,
                       output longint rs, output bit rc, output bit ro);
    longint m, half, sa, sb, r;
    m = longint'(1) << w;
    half = m / 2;
    if (!s) begin
      rs = (ua + ub) % m;
      rc = (ua + ub) >= m;
    end else begin
      rs = (ua - ub + m) % m;
      rc = ua >= ub;
    end
    sa = (ua >= half) ? ua - m : ua;
    sb = (ub >= half) ? ub - m : ub;
    r  = s ? sa - sb : sa + sb;
    ro = (r >= half) || (r < -half);
  endtask

  // Apply start for one edge; returns at the negedge of the cycle after acceptance.
  task automatic launch(input int sel, input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    a_v = a; b_v = b; sub_v = s; start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Wait (bounded) for done and check latency, busy length and results; returns at the done cycle.
  task automatic finish_op(input int sel, input int steps, input int cyc0, input logic [15:0] es,
                           input logic ec, input logic ez, input logic eo, input string name);
    int cyc = cyc0;
    int busy_cnt = 0;
    while (!done_o[sel] && cyc <= 40) begin
      if (busy_o[sel]) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("%s latency", name), cyc, steps + 1);
    chk($sformatf("%s busy", name), busy_cnt, steps + 1 - cyc0);
    chk($sformatf("%s sum", name), get_sum(sel), es);
    chk($sformatf("%s flags", name), {busy_o[sel], cout_o[sel], zero_o[sel], ovf_o[sel]},
        {1'b0, ec, ez, eo & OVF_EN});
  endtask

  task automatic rand_op(input int sel, input int w, input int steps, input int idx);
    logic [15:0] a, b, m;
    logic s;
    longint rs;
    bit rc, ro;
    m = (w == 16) ? 16'hFFFF : 16'h00FF;
    a = 16'($urandom) & m;
    b = 16'($urandom) & m;
    if ($urandom_range(0, 3) == 0) b = a;
    s = 1'($urandom_range(0, 1));
    model(w, longint'(a), longint'(b), s, rs, rc, ro);
    launch(sel, a, b, s);
    finish_op(sel, steps, 1, 16'(rs), rc, (rs == 0), ro,
              $sformatf("rnd%0d_w%0d %h%s%h", idx, w, a, s ? "-" : "+", b));
  endtask

  vec_t vecs[7];

  initial begin
    int pulses;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h10, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset dut8", {busy_o[0], done_o[0], sum0, cout_o[0], zero_o[0], ovf_o[0]}, 0);
    chk("reset dut16", {busy_o[1], done_o[1], sum1, cout_o[1], zero_o[1], ovf_o[1]}, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      launch(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].sub);
      finish_op(0, 8, 1, {8'h00, vecs[i].sum}, vecs[i].cout, vecs[i].zero, vecs[i].ovf,
                $sformatf("vec%0d", i));
      $display("vec%0d: %h %s %h -> sum=%h c=%b z=%b v=%b", i, vecs[i].a,
               vecs[i].sub ? "-" : "+", vecs[i].b, sum0, cout_o[0], zero_o[0], ovf_o[0]);
    end
    @(negedge clk);
    chk("done one cycle", done_o[0], 1'b0);

    // start during RUN is ignored
    launch(0, 16'h000F, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_v = 16'h0000; b_v = 16'h0000; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    finish_op(0, 8, 4, 16'h0010, 1'b0, 1'b0, 1'b0, "ignore_start");
    $display("ignore_start: sum=%h", sum0);

    // back-to-back: start accepted in the DONE cycle
    a_v = 16'h0001; b_v = 16'h0001; sub_v = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    finish_op(0, 8, 1, 16'h0002, 1'b0, 1'b0, 1'b0, "back_to_back");
    $display("back_to_back: sum=%h", sum0);

    // reset mid-operation
    launch(0, 16'h000F, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset outputs", {busy_o[0], done_o[0], sum0, cout_o[0]}, 0);
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o[0]) pulses++;
    end
    chk("mid_reset no done", pulses, 0);
    $display("mid_reset: done pulses=%0d", pulses);
    launch(0, 16'h0033, 16'h0011, 1'b1);
    finish_op(0, 8, 1, 16'h0022, 1'b1, 1'b0, 1'b0, "after_reset");

    // 16-bit, 4 bits per cycle
    launch(1, 16'hFFFF, 16'h0001, 1'b0);
    finish_op(1, 4, 1, 16'h0000, 1'b1, 1'b1, 1'b0, "w16_wrap");
    $display("w16_wrap: sum=%h c=%b z=%b", sum1, cout_o[1], zero_o[1]);

    for (int i = 0; i < 20; i++) begin
      rand_op(0, 8, 8, i);
      $display("rnd8 %0d: sum=%h c=%b z=%b v=%b", i, sum0, cout_o[0], zero_o[0], ovf_o[0]);
    end
    for (int i = 0; i < 12; i++) begin
      rand_op(1, 16, 4, i);
      $display("rnd16 %0d: sum=%h c=%b z=%b v=%b", i, sum1, cout_o[1], zero_o[1], ovf_o[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
